feed_dispenser_ctrl: RTL and testbench

Consumer of the interval counter's dispense request (`switch_i_c`) in the pet-feeder datapath. On each new request it runs the feed motor until the bowl reports full, or until a portion limit is reached. It then holds a settle window, reports the completed meal and counts it. An empty tank is reported as a latched fault that software must clear.

---
 rtl/feeder_pkg.sv | 15 +
 rtl/rise_detect.sv | 23 ++
 rtl/feed_dispenser_ctrl.sv | 137 +++++++++++++
 tb/tb_feed_dispenser_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// Shared types for the pet-feeder dispenser: controller state encoding and fault codes.
package feeder_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StSettle,
      StFault
   } state_e;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_TANK    = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: flags a cycle where level is high and was low the cycle before.
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level;
      end
   end

   always_comb begin
      rise = level & ~prev_q;
   end

endmodule

// File: rtl/feed_dispenser_ctrl.sv
// Feed dispenser controller: runs the motor per request, settles, counts meals, latches faults.
// Define DISPENSE_TIMEOUT_EN to turn a reached portion limit into a timeout fault.
module feed_dispenser_ctrl
   import feeder_pkg::*;
#(
   parameter int unsigned MOTOR_MAX_CYCLES = 8,
   parameter int unsigned SETTLE_CYCLES    = 2,
   parameter int unsigned MEAL_CNT_W       = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  switch_i_c,
   input  logic                  full_bowl_sensor,
   input  logic                  empty_tank_sensor,
   input  logic                  fault_clear,
   output logic                  motor_on,
   output logic                  dispensing,
   output logic                  meal_done,
   output logic                  fault,
   output logic [1:0]            fault_code,
   output logic [MEAL_CNT_W-1:0] meal_count
);

   localparam int unsigned RunW = (MOTOR_MAX_CYCLES > 2) ? $clog2(MOTOR_MAX_CYCLES) : 1;
   localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [RunW-1:0] RunLast = RunW'(MOTOR_MAX_CYCLES - 1);
   localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYCLES - 1);

   state_e                state_q, state_d;
   logic [RunW-1:0]       run_cnt_q, run_cnt_d;
   logic [SetW-1:0]       set_cnt_q, set_cnt_d;
   logic [1:0]            code_q, code_d;
   logic                  done_q, done_d;
   logic                  motor_q;
   logic [MEAL_CNT_W-1:0] count_q;
   logic                  request;

   rise_detect u_rise (
      .clock (clock),
      .reset (reset),
      .level (switch_i_c),
      .rise  (request)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         run_cnt_q <= '0;
         set_cnt_q <= '0;
         code_q    <= FAULT_NONE;
         done_q    <= 1'b0;
         motor_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
         set_cnt_q <= set_cnt_d;
         code_q    <= code_d;
         done_q    <= done_d;
         // Motor drive comes straight from a flop so it cannot glitch on state decode.
         motor_q   <= (state_d == StRun);
         if (done_d) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      set_cnt_d = set_cnt_q;
      code_d    = code_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (request && enable) begin
               if (empty_tank_sensor) begin
                  state_d = StFault;
                  code_d  = FAULT_TANK;
               end else if (!full_bowl_sensor) begin
                  state_d   = StRun;
                  run_cnt_d = '0;
               end
            end
         end
         StRun: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (empty_tank_sensor) begin
               state_d = StFault;
               code_d  = FAULT_TANK;
            end else if (full_bowl_sensor) begin
               state_d   = StSettle;
               set_cnt_d = '0;
            end else if (run_cnt_q == RunLast) begin
`ifdef DISPENSE_TIMEOUT_EN
               state_d = StFault;
               code_d  = FAULT_TIMEOUT;
`else
               state_d   = StSettle;
               set_cnt_d = '0;
`endif
            end else begin
               run_cnt_d = run_cnt_q + 1'b1;
            end
         end
         StSettle: begin
            if (set_cnt_q == SetLast) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else begin
               set_cnt_d = set_cnt_q + 1'b1;
            end
         end
         StFault: begin
            if (fault_clear && !empty_tank_sensor) begin
               state_d = StIdle;
               code_d  = FAULT_NONE;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      motor_on   = motor_q;
      dispensing = (state_q == StRun) || (state_q == StSettle);
      meal_done  = done_q;
      fault      = (state_q == StFault);
      fault_code = code_q;
      meal_count = count_q;
   end

endmodule

// File: tb/tb_feed_dispenser_ctrl.sv
// Directed bench for feed_dispenser_ctrl with a per-cycle expectation scoreboard.
module tb_feed_dispenser_ctrl;

`ifdef DISPENSE_TIMEOUT_EN
   localparam bit To = 1'b1;
`else
   localparam bit To = 1'b0;
`endif

   // Inputs packed as {sw, full, empty, enable, clear, reset}.
   localparam logic [5:0] IIdle  = 6'b000100;
   localparam logic [5:0] IReq   = 6'b100100;
   localparam logic [5:0] IFull  = 6'b010100;
   localparam logic [5:0] IEmpty = 6'b001100;
   // Outputs packed as {motor, dispensing, done, fault, code}.
   localparam logic [5:0] ORun   = 6'b110000;
   localparam logic [5:0] OSet   = 6'b010000;
   localparam logic [5:0] ODone  = 6'b001000;
   localparam logic [5:0] OIdle  = 6'b000000;
   localparam logic [5:0] OTank  = 6'b000101;

   logic clock = 1'b0;
   logic reset, enable, sw, full, empty, clr;
   logic motor, disp, done, flt;
   logic [1:0] code;
   logic [15:0] cnt;
   logic motor2, disp2, done2, flt2;
   logic [1:0] code2;
   logic [1:0] cnt2;

   int vectors = 0;
   int miscompares = 0;
   int meals = 0;

   typedef struct {
      string      tag;
      logic [5:0] o;
      int         n;
   } exp_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   feed_dispenser_ctrl dut (
      .clock             (clock),
      .reset             (reset),
      .enable            (enable),
      .switch_i_c        (sw),
      .full_bowl_sensor  (full),
      .empty_tank_sensor (empty),
      .fault_clear       (clr),
      .motor_on          (motor),
      .dispensing        (disp),
      .meal_done         (done),
      .fault             (flt),
      .fault_code        (code),
      .meal_count        (cnt)
   );

   feed_dispenser_ctrl #(.MEAL_CNT_W(2)) dut_w2 (
      .clock             (clock),
      .reset             (reset),
      .enable            (enable),
      .switch_i_c        (sw),
      .full_bowl_sensor  (full),
      .empty_tank_sensor (empty),
      .fault_clear       (clr),
      .motor_on          (motor2),
      .dispensing        (disp2),
      .meal_done         (done2),
      .fault             (flt2),
      .fault_code        (code2),
      .meal_count        (cnt2)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
   task automatic cyc(input string tag, input logic [5:0] in, input logic [5:0] out);
      exp_t x;
      @(negedge clock);
      {sw, full, empty, enable, clr, reset} = in;
      x.tag = tag;
      x.o   = out;
      x.n   = meals;
      sb.push_back(x);
      @(posedge clock);
      #1;
      x = sb.pop_front();
      check({x.tag, ".motor"}, 16'(motor), 16'(x.o[5]));
      check({x.tag, ".disp"},  16'(disp),  16'(x.o[4]));
      check({x.tag, ".done"},  16'(done),  16'(x.o[3]));
      check({x.tag, ".fault"}, 16'(flt),   16'(x.o[2]));
      check({x.tag, ".code"},  16'(code),  16'(x.o[1:0]));
      check({x.tag, ".count"}, cnt,        16'(x.n));
      check({x.tag, ".motor2"}, 16'(motor2), 16'(x.o[5]));
      check({x.tag, ".count2"}, 16'(cnt2),   16'(x.n % 4));
   endtask

   initial begin
      {sw, full, empty, enable, clr} = 5'b0;
      reset = 1'b1;

      cyc("rst0", 6'b000001, OIdle);
      cyc("rst1", 6'b000101, OIdle);

      // Normal meal, switch held two cycles, bowl full sampled in cycle 3.
      cyc("n.c0", IReq, ORun);
      cyc("n.c1", IReq, ORun);
      cyc("n.c2", IIdle, ORun);
      cyc("n.c3", IFull, OSet);
      cyc("n.c4", IFull, OSet);
      meals++;
      cyc("n.c5", IIdle, ODone);
      cyc("n.c6", IIdle, OIdle);

      // No bowl-full: portion limit after eight motor cycles.
      cyc("to.c0", IReq, ORun);
      for (int i = 1; i <= 7; i++) cyc("to.run", IIdle, ORun);
      cyc("to.c8", IIdle, {1'b0, !To, 1'b0, To, To, 1'b0});
      cyc("to.c9", IIdle, {1'b0, !To, 1'b0, To, To, 1'b0});
      meals += To ? 0 : 1;
      cyc("to.c10", IIdle, {1'b0, 1'b0, !To, To, To, 1'b0});
      cyc("to.c11", 6'b000110, OIdle);

      // Tank runs empty mid-meal; clear ignored while still empty.
      cyc("t.c0", IReq, ORun);
      cyc("t.c1", IIdle, ORun);
      cyc("t.c2", IEmpty, OTank);
      cyc("t.c3", 6'b001110, OTank);
      cyc("t.c4", IIdle, OTank);
      cyc("t.c5", 6'b000110, OIdle);
      cyc("t.c6", IIdle, OIdle);

      // Request while tank is empty goes straight to fault.
      cyc("te.c0", 6'b101100, OTank);
      cyc("te.c1", 6'b000110, OIdle);

      // Switch held five cycles yields a single meal.
      cyc("h.c0", IReq, ORun);
      cyc("h.c1", IReq, ORun);
      cyc("h.c2", 6'b110100, OSet);
      cyc("h.c3", IReq, OSet);
      meals++;
      cyc("h.c4", IReq, ODone);
      cyc("h.c5", IIdle, OIdle);
      cyc("h.c6", IIdle, OIdle);

      // Request with bowl already full is ignored.
      cyc("bf.c0", 6'b110100, OIdle);
      cyc("bf.c1", IIdle, OIdle);

      // Enable dropped in cycle 4 aborts; request with enable low is ignored.
      cyc("e.c0", IReq, ORun);
      for (int i = 1; i <= 3; i++) cyc("e.run", IIdle, ORun);
      cyc("e.c4", 6'b000000, OIdle);
      cyc("e.c5", 6'b000000, OIdle);
      cyc("e.c6", 6'b100000, OIdle);
      cyc("e.c7", IIdle, OIdle);

      // Reset in RUN clears everything including the meal count.
      cyc("r.c0", IReq, ORun);
      cyc("r.c1", IIdle, ORun);
      meals = 0;
      cyc("r.c2", 6'b000101, OIdle);
      cyc("r.c3", IIdle, OIdle);

      // Four short meals back to back; each new request lands in the meal_done cycle.
      for (int k = 0; k < 4; k++) begin
         cyc("w.k0", IReq, ORun);
         cyc("w.k1", IFull, OSet);
         cyc("w.k2", IIdle, OSet);
         meals++;
         cyc("w.k3", IIdle, ODone);
      end
      cyc("w.end", IIdle, OIdle);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
